// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetches one 16-bit little-endian instruction as two byte reads from memory.
// The address comes straight from the PC output of the address register file;
// the PC is advanced by this unit through ArfRegSel/ArfFunSel on every byte
// that memory actually delivers.  Each byte request may wait for MemReady up
// to TIMEOUT cycles before the fetch is abandoned with an Error pulse.
//
// Ports
//   Clock      : single clock, rising edge
//   Reset      : synchronous, active-high
//   Start      : fetch request, only looked at while idle
//   PcIn[15:0] : current PC from the address register file
//   MemData[7:0], MemReady : memory read data and its completion strobe
//   MemAddr[15:0], MemRead : memory read request (MemAddr = PcIn while reading)
//   ArfFunSel[2:0], ArfRegSel[2:0] : register file control (RegSel active-low)
//   IR[15:0]   : last successfully fetched instruction
//   Busy       : fetch in progress (any state other than idle)
//   Done       : one-cycle pulse after a successful fetch
//   Error      : one-cycle pulse after a timed-out fetch
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int unsigned TIMEOUT = 15,
  parameter logic [2:0]  FUN_INC = 3'b001
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] PcIn,
  input  logic [7:0]  MemData,
  input  logic        MemReady,
  output logic [15:0] MemAddr,
  output logic        MemRead,
  output logic [2:0]  ArfFunSel,
  output logic [2:0]  ArfRegSel,
  output logic [15:0] IR,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_LO = 2'd1,
    REQ_HI = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Last counter value at which a missing MemReady still ends the request.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  // RegSel is active-low: only bit 2 (PC) low selects the PC for increment.
  localparam logic [2:0] REGSEL_PC   = 3'b011;
  localparam logic [2:0] REGSEL_NONE = 3'b111;
  localparam logic [2:0] FUNSEL_NOP  = 3'b000;

  state_t      state_q, state_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  wait_q, wait_d;
  logic        error_q, error_d;

  logic        mem_read;
  logic        pc_inc;
  logic        done;

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    ir_d     = ir_q;
    wait_d   = wait_q;
    error_d  = 1'b0;
    mem_read = 1'b0;
    pc_inc   = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = REQ_LO;
          wait_d  = 8'd0;
        end
      end

      REQ_LO: begin
        mem_read = 1'b1;
        if (MemReady) begin
          // A byte served on the final wait cycle still counts as success.
          pc_inc  = 1'b1;
          lo_d    = MemData;
          wait_d  = 8'd0;
          state_d = REQ_HI;
        end else if (wait_q == WAIT_LAST) begin
          error_d = 1'b1;
          wait_d  = 8'd0;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      REQ_HI: begin
        mem_read = 1'b1;
        if (MemReady) begin
          pc_inc  = 1'b1;
          ir_d    = {MemData, lo_q};
          wait_d  = 8'd0;
          state_d = DONE;
        end else if (wait_q == WAIT_LAST) begin
          // The low-byte increment already happened and is deliberately kept.
          error_d = 1'b1;
          wait_d  = 8'd0;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      lo_q    <= 8'h00;
      ir_q    <= 16'h0000;
      wait_q  <= 8'h00;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
      error_q <= error_d;
    end
  end

  assign MemRead   = mem_read;
  assign MemAddr   = mem_read ? PcIn : 16'h0000;
  assign ArfRegSel = pc_inc ? REGSEL_PC : REGSEL_NONE;
  assign ArfFunSel = pc_inc ? FUN_INC : FUNSEL_NOP;
  assign IR        = ir_q;
  assign Busy      = (state_q != IDLE);
  assign Done      = done;
  // Error is only ever set on the edge into IDLE, so it cannot overlap Done.
  assign Error     = error_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed bench for instruction_fetch_unit.  A small PC register stands in
// for the address register file and follows the DUT's RegSel/FunSel.  A
// transaction-level model (bytes received, wait cycles, pending Done/Error)
// predicts every output each cycle; directed scenarios add literal checks on
// cycle numbers, IR values and increment counts.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam int unsigned TIMEOUT = 15;
  localparam logic [2:0]  FUN_INC = 3'b001;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [15:0] PcIn;
  logic [7:0]  MemData;
  logic        MemReady;
  logic [15:0] MemAddr;
  logic        MemRead;
  logic [2:0]  ArfFunSel;
  logic [2:0]  ArfRegSel;
  logic [15:0] IR;
  logic        Busy;
  logic        Done;
  logic        Error;

  instruction_fetch_unit #(
    .TIMEOUT(TIMEOUT),
    .FUN_INC(FUN_INC)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .PcIn     (PcIn),
    .MemData  (MemData),
    .MemReady (MemReady),
    .MemAddr  (MemAddr),
    .MemRead  (MemRead),
    .ArfFunSel(ArfFunSel),
    .ArfRegSel(ArfRegSel),
    .IR       (IR),
    .Busy     (Busy),
    .Done     (Done),
    .Error    (Error)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- PC register stand-in -----------------------------------
  logic [15:0] pc_reg;
  logic        pc_load;
  logic [15:0] pc_load_val;
  int          inc_events = 0;

  assign PcIn = pc_reg;

  always @(posedge Clock) begin
    if (pc_load) begin
      pc_reg <= pc_load_val;
    end else if (!ArfRegSel[2] && ArfFunSel == FUN_INC) begin
      pc_reg <= pc_reg + 16'd1;
    end
    if (ArfRegSel == 3'b011 && ArfFunSel == FUN_INC) inc_events++;
  end

  // ---------------- transaction-level model --------------------------------
  bit          started = 0;
  bit          m_in_fetch = 0;   // a byte request is outstanding
  int          m_bytes = 0;      // bytes already received in this fetch
  int          m_wait = 0;       // cycles waited for the current byte
  bit          m_finishing = 0;  // Done cycle
  bit          m_err = 0;        // Error cycle
  logic [7:0]  m_lo = 8'h00;
  logic [15:0] m_ir = 16'h0000;
  logic [15:0] m_pc = 16'h0000;

  always @(negedge Clock) begin
    bit exp_inc;
    exp_inc = m_in_fetch && MemReady;
    if (started) begin
      chk("busy",   32'(Busy),      32'(m_in_fetch || m_finishing));
      chk("memread",32'(MemRead),   32'(m_in_fetch));
      if (m_in_fetch) chk("memaddr", 32'(MemAddr), 32'(m_pc));
      chk("pc",     32'(PcIn),      32'(m_pc));
      chk("regsel", 32'(ArfRegSel), exp_inc ? 32'h3 : 32'h7);
      chk("funsel", 32'(ArfFunSel), exp_inc ? 32'(FUN_INC) : 32'h0);
      chk("done",   32'(Done),      32'(m_finishing));
      chk("error",  32'(Error),     32'(m_err));
      chk("ir",     32'(IR),        32'(m_ir));
    end
    // PC follows loads and the increments the model expects.
    if (pc_load) m_pc = pc_load_val;
    else if (started && exp_inc) m_pc = m_pc + 16'd1;
    // Advance the fetch model across the coming rising edge.
    if (Reset) begin
      started = 1;
      m_in_fetch = 0; m_bytes = 0; m_wait = 0;
      m_finishing = 0; m_err = 0; m_lo = 8'h00; m_ir = 16'h0000;
    end else if (started) begin
      m_err = 0;
      if (m_finishing) begin
        m_finishing = 0;
      end else if (m_in_fetch) begin
        if (MemReady) begin
          if (m_bytes == 0) begin
            m_lo = MemData; m_bytes = 1; m_wait = 0;
          end else begin
            m_ir = {MemData, m_lo}; m_in_fetch = 0; m_finishing = 1;
          end
        end else begin
          m_wait++;
          if (m_wait == int'(TIMEOUT)) begin
            m_in_fetch = 0; m_err = 1;
          end
        end
      end else if (Start) begin
        m_in_fetch = 1; m_bytes = 0; m_wait = 0;
      end
    end
  end

  // ---------------- stimulus ------------------------------------------------
  // Apply one cycle's inputs, then move to just after the next rising edge.
  task automatic cyc(input bit rst, input bit st, input bit rdy, input logic [7:0] d);
    Reset = rst; Start = st; MemReady = rdy; MemData = d;
    @(posedge Clock); #1;
  endtask

  task automatic load_pc(input logic [15:0] v);
    pc_load = 1'b1; pc_load_val = v;
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    pc_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int inc0;
    int dones;
    bit [7:0] done_at;

    pc_load = 1'b1; pc_load_val = 16'h0040;
    Reset = 1'b1; Start = 1'b1; MemReady = 1'b1; MemData = 8'hEE;
    @(posedge Clock); #1;
    cyc(1'b1, 1'b1, 1'b1, 8'hEE);
    pc_load = 1'b0;
    Reset = 1'b0; Start = 1'b0; MemReady = 1'b0;
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_ir", 32'(IR), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_error", 32'(Error), 0);
    chk("rst_memread", 32'(MemRead), 0);
    chk("rst_regsel", 32'(ArfRegSel), 32'h7);
    chk("rst_funsel", 32'(ArfFunSel), 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 8'h99);   // MemReady ignored while idle
    chk("idle_ignore_ready", 32'(Busy), 0);

    // Basic fetch: Start in cycle 0, bytes in cycles 1 and 2, Done in 3.
    inc0 = inc_events;
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("basic_addr_lo", 32'(MemAddr), 32'h0040);
    cyc(1'b0, 1'b0, 1'b1, 8'h34);
    chk("basic_addr_hi", 32'(MemAddr), 32'h0041);
    chk("basic_ir_partial", 32'(IR), 0);
    cyc(1'b0, 1'b0, 1'b1, 8'h12);
    chk("basic_done_c3", 32'(Done), 1);
    chk("basic_ir", 32'(IR), 32'h1234);
    chk("basic_incs", 32'(inc_events - inc0), 2);
    chk("basic_pc", 32'(PcIn), 32'h0042);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("basic_done_pulse", 32'(Done), 0);
    $display("txn basic fetch pc=0040 ir=%h", IR);

    // Wait states: three idle MemReady cycles before each byte, Done in 9.
    load_pc(16'h0100);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'hAB);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("wait_ir_hold", 32'(IR), 32'h1234);
    chk("wait_memread", 32'(MemRead), 1);
    cyc(1'b0, 1'b0, 1'b1, 8'hCD);
    chk("wait_done_c9", 32'(Done), 1);
    chk("wait_ir", 32'(IR), 32'hCDAB);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    $display("txn wait-state fetch pc=0100 ir=%h", IR);

    // Timeout with no byte served: 15 REQ_LO cycles, Error in cycle 16.
    inc0 = inc_events;
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= 14; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("to_busy_c15", 32'(Busy), 1);
    chk("to_error_early", 32'(Error), 0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("to_error_c16", 32'(Error), 1);
    chk("to_busy_c16", 32'(Busy), 0);
    chk("to_ir", 32'(IR), 32'hCDAB);
    chk("to_incs", 32'(inc_events - inc0), 0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("to_error_pulse", 32'(Error), 0);
    $display("txn timeout (no bytes) ir=%h", IR);

    // Partial timeout: low byte served, high byte never.
    inc0 = inc_events;
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h55);
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("pto_error_early", 32'(Error), 0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("pto_error", 32'(Error), 1);
    chk("pto_ir", 32'(IR), 32'hCDAB);
    chk("pto_incs", 32'(inc_events - inc0), 1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    $display("txn partial timeout ir=%h", IR);

    // MemReady on the last allowed wait cycle is a success.
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h9A);
    chk("edge_no_error", 32'(Error), 0);
    chk("edge_busy", 32'(Busy), 1);
    cyc(1'b0, 1'b0, 1'b1, 8'hBC);
    chk("edge_done", 32'(Done), 1);
    chk("edge_ir", 32'(IR), 32'hBC9A);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    $display("txn last-cycle ready ir=%h", IR);

    // Reset in REQ_HI, then a clean fetch.
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h11);
    cyc(1'b1, 1'b1, 1'b1, 8'h22);
    Reset = 1'b0;
    chk("rmid_busy", 32'(Busy), 0);
    chk("rmid_ir", 32'(IR), 0);
    chk("rmid_memread", 32'(MemRead), 0);
    chk("rmid_done", 32'(Done), 0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h66);
    cyc(1'b0, 1'b0, 1'b1, 8'h77);
    chk("rmid_clean_done", 32'(Done), 1);
    chk("rmid_clean_ir", 32'(IR), 32'h7766);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    $display("txn reset mid-fetch then fetch ir=%h", IR);

    // Start held high with memory always ready: Done in cycles 3 and 7.
    dones = 0; done_at = 8'h00;
    for (int c = 0; c < 8; c++) begin
      cyc(1'b0, 1'b1, 1'b1, 8'(8'h80 + c));
      if (Done) begin
        dones++;
        done_at[c + 1] = 1'b1;
      end
    end
    chk("b2b_dones", 32'(dones), 2);
    chk("b2b_done_cycles", 32'(done_at), 32'h88);
    chk("b2b_ir", 32'(IR), 32'h8685);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    $display("txn back-to-back fetches ir=%h", IR);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter TIMEOUT, default 15: max wait cycles for MemReady per byte request; legal range 1..255.
REQ-002 Parameter FUN_INC, default 3'b001: FunSel code driven to the address register file for increment.
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  fetch request; sampled only in IDLE.
REQ-006 PcIn  input  16  current PC value from the address register file output port.
REQ-007 MemData  input  8  byte read from memory; valid when MemReady=1.
REQ-008 MemReady  input  1  memory read-complete strobe.
REQ-009 MemAddr  output  16  memory address; equals PcIn whenever MemRead=1.
REQ-010 MemRead  output  1  memory read request.
REQ-011 ArfFunSel  output  3  FunSel to the address register file.
REQ-012 ArfRegSel  output  3  RegSel to the address register file; active-low enables, bit 2 = PC, bit 1 = AR, bit 0 = SP.
REQ-013 IR  output  16  assembled instruction word, little-endian.
REQ-014 Busy  output  1  high in any state other than IDLE.
REQ-015 Done  output  1  one-cycle pulse on successful fetch.
REQ-016 Error  output  1  one-cycle pulse on timeout.

Function
REQ-017 The FSM SHALL have states IDLE, REQ_LO, REQ_HI, and DONE.
REQ-018 IDLE: if Start=1, go to REQ_LO next cycle; otherwise stay. MemReady is ignored in IDLE.
REQ-019 REQ_LO/REQ_HI: MemRead=1, MemAddr=PcIn (combinational).
REQ-020 REQ_LO with MemReady=1: latch MemData into the internal low-byte holding register, go to REQ_HI.
REQ-021 REQ_HI with MemReady=1: load IR <= {MemData, low-byte holding register} at that edge, go to DONE.
REQ-022 In any REQ cycle with MemReady=1, drive ArfRegSel=3'b011 and ArfFunSel=FUN_INC for that cycle only (PC increments at that edge).
REQ-023 In all other cycles, drive ArfRegSel=3'b111 and ArfFunSel=3'b000, so no register is enabled.
REQ-024 Minimum fetch latency: Start in cycle 0 -> Done in cycle 3, with MemReady asserted in cycles 1 and 2.
REQ-025 DONE: Done=1 for one cycle, then go to IDLE. A Start sampled in DONE is ignored.
REQ-026 Start while Busy=1 SHALL be ignored, not queued.
REQ-027 IR SHALL change only at the REQ_HI->DONE edge, never on a partial fetch.
REQ-028 Wait counter (8 bits):
- Cleared on entry to each REQ state.
- Increments every REQ cycle with MemReady=0.
- When a REQ cycle with MemReady=0 occurs with counter = TIMEOUT-1: go to IDLE, pulse Error=1 for one cycle (asserted in the following IDLE cycle), leave IR unchanged.
REQ-029 A PC increment already issued for the low byte SHALL NOT be rolled back on timeout.
REQ-030 MemReady=1 on the same cycle the timeout would fire counts as success; no Error.
REQ-031 Done and Error SHALL never be high simultaneously.

Reset
REQ-032 Reset=1 at a clock edge, in any state including mid-fetch, SHALL force the following next cycle:
- state IDLE; IR=16'h0000; holding register and counter cleared;
- MemRead=0, Busy=0, Done=0, Error=0;
- ArfRegSel=3'b111, ArfFunSel=3'b000.
REQ-033 Reset SHALL take priority over Start and MemReady.

Verification
REQ-034 Basic fetch: PcIn=16'h0040, Start=1, MemReady=1 on cycles 1 and 2 with MemData=8'h34 then 8'h12 -> IR=16'h1234 and Done=1 in cycle 3; exactly two increment cycles (RegSel=3'b011, FunSel=3'b001); MemAddr=16'h0040 then 16'h0041.
REQ-035 Wait states: MemReady delayed 3 cycles per byte -> Done in cycle 9; MemRead held high throughout; IR unchanged until the Done cycle.
REQ-036 Timeout: TIMEOUT=15, MemReady never asserted -> Error pulse exactly once after 15 REQ_LO cycles; IR retains its prior value; no increment issued.
REQ-037 Partial timeout: low byte served, high byte never served -> one increment issued, then Error; IR unchanged.
REQ-038 Reset mid-fetch: Reset asserted in REQ_HI -> all REQ-032 values next cycle; a subsequent Start performs a clean fetch.
REQ-039 Start held high continuously -> back-to-back fetches with one IDLE cycle between the Done pulse and the next REQ_LO; no Start is captured during Busy.
